// File: rtl/memshare_l1pa_shift_collector_if.sv
// Beat input and group output bundle for the L1PA shift collector.
// conflict_o exists only when MEMSHARE_COLLECT_CONFLICT_CHECK_EN is defined.
interface memshare_l1pa_shift_collector_if #(
    parameter int SHARE_GROUP_SIZE = 5,
    parameter int MSG_BITWIDTH     = 4,
    parameter int MAX_SEQ_LEN      = 4
);
    localparam int SW = (SHARE_GROUP_SIZE > 1) ? $clog2(SHARE_GROUP_SIZE) : 1;
    localparam int BW = $clog2(MAX_SEQ_LEN) + 1;

    logic                                     in_valid_i;
    logic                                     in_ready_o;
    logic [SW-1:0]                            l1pa_shift_i;
    logic                                     isGtr_i;
    logic [SHARE_GROUP_SIZE-1:0]              lane_mask_i;
    logic [SHARE_GROUP_SIZE*MSG_BITWIDTH-1:0] rdata_i;
    logic                                     out_valid_o;
    logic                                     out_ready_i;
    logic [SHARE_GROUP_SIZE*MSG_BITWIDTH-1:0] out_data_o;
    logic [SHARE_GROUP_SIZE-1:0]              out_lane_mask_o;
    logic [BW-1:0]                            out_beats_o;
    logic                                     seq_err_o;
    logic                                     err_o;
`ifdef MEMSHARE_COLLECT_CONFLICT_CHECK_EN
    logic                                     conflict_o;
`endif

    modport slave (
        input  in_valid_i, l1pa_shift_i, isGtr_i, lane_mask_i, rdata_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_lane_mask_o, out_beats_o,
`ifdef MEMSHARE_COLLECT_CONFLICT_CHECK_EN
        output conflict_o,
`endif
        output seq_err_o, err_o
    );

    modport master (
        output in_valid_i, l1pa_shift_i, isGtr_i, lane_mask_i, rdata_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_lane_mask_o, out_beats_o,
`ifdef MEMSHARE_COLLECT_CONFLICT_CHECK_EN
        input  conflict_o,
`endif
        input  seq_err_o, err_o
    );
endinterface

// File: rtl/memshare_l1pa_shift_collector.sv
// Rotates each buffer beat into canonical lane order and merges it into a share-group
// accumulator; closes on isGtr or overflow. Optional macro: MEMSHARE_COLLECT_CONFLICT_CHECK_EN.
module memshare_l1pa_shift_collector #(
    parameter int SHARE_GROUP_SIZE = 5,
    parameter int MSG_BITWIDTH     = 4,
    parameter int MAX_SEQ_LEN      = 4
) (
    input logic                            sys_clk,
    input logic                            rstn,
    memshare_l1pa_shift_collector_if.slave bus
);
    localparam int N  = SHARE_GROUP_SIZE;
    localparam int W  = MSG_BITWIDTH;
    localparam int BW = $clog2(MAX_SEQ_LEN) + 1;

    logic [N-1:0][W-1:0] w_rdata, w_rot, w_acc_nxt, r_acc, r_out_data;
    logic [N-1:0]        w_wmask, w_mask_nxt, r_mask, r_out_mask;
    logic [BW-1:0]       r_cnt, r_out_beats;
    logic                w_fire, w_legal, w_ovf, w_close, w_err;
    logic                r_out_valid, r_seq_err, r_err;

    assign w_rdata = bus.rdata_i;
    assign w_legal = int'(bus.l1pa_shift_i) < N;
    assign w_fire  = bus.in_valid_i & bus.in_ready_o;
    assign w_ovf   = !bus.isGtr_i && (r_cnt == BW'(MAX_SEQ_LEN - 1));
    assign w_close = w_fire & (bus.isGtr_i | w_ovf);

    // Illegal shifts still count as a beat but write no lanes.
    assign w_wmask    = w_legal ? bus.lane_mask_i : '0;
    assign w_mask_nxt = r_mask | w_wmask;

    always_comb begin
        w_rot     = '0;
        w_acc_nxt = r_acc;
        for (int k = 0; k < N; k++) begin
            w_rot[k] = w_rdata[(k + int'(bus.l1pa_shift_i)) % N];
            if (w_wmask[k]) w_acc_nxt[k] = w_rot[k];
        end
    end

`ifdef MEMSHARE_COLLECT_CONFLICT_CHECK_EN
    logic w_conf, r_conf, r_out_conf;
    assign w_conf = |(w_wmask & r_mask);
    assign w_err  = !w_legal | w_ovf | w_conf;
    assign bus.conflict_o = r_out_conf;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_conf     <= 1'b0;
            r_out_conf <= 1'b0;
        end else if (w_fire) begin
            if (w_close) begin
                r_out_conf <= r_conf | w_conf;
                r_conf     <= 1'b0;
            end else begin
                r_conf     <= r_conf | w_conf;
            end
        end
    end
`else
    assign w_err = !w_legal | w_ovf;
`endif

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_acc       <= '0;
            r_mask      <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_mask  <= '0;
            r_out_beats <= '0;
            r_seq_err   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (r_out_valid && bus.out_ready_i) r_out_valid <= 1'b0;
            if (w_fire) begin
                if (w_close) begin
                    // A close in the same edge as a drain wins and reloads the slot.
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_acc_nxt;
                    r_out_mask  <= w_mask_nxt;
                    r_out_beats <= r_cnt + BW'(1);
                    r_seq_err   <= w_ovf;
                    r_acc       <= '0;
                    r_mask      <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc       <= w_acc_nxt;
                    r_mask      <= w_mask_nxt;
                    r_cnt       <= r_cnt + BW'(1);
                end
                if (w_err) r_err <= 1'b1;
            end
        end
    end

    assign bus.in_ready_o      = !r_out_valid | bus.out_ready_i;
    assign bus.out_valid_o     = r_out_valid;
    assign bus.out_data_o      = r_out_data;
    assign bus.out_lane_mask_o = r_out_mask;
    assign bus.out_beats_o     = r_out_beats;
    assign bus.seq_err_o       = r_seq_err;
    assign bus.err_o           = r_err;
endmodule

// File: tb/tb_memshare_l1pa_shift_collector.sv
// Scoreboard bench for memshare_l1pa_shift_collector: directed cases then random beats
// checked against a lane-array model of the collection rules.
module tb_memshare_l1pa_shift_collector;
    localparam int N = 5;
    localparam int W = 4;
    localparam int M = 4;

    logic sys_clk = 1'b0;
    logic rstn    = 1'b0;
    always #5 sys_clk = ~sys_clk;

    memshare_l1pa_shift_collector_if #(.SHARE_GROUP_SIZE(N), .MSG_BITWIDTH(W), .MAX_SEQ_LEN(M)) bus();

    memshare_l1pa_shift_collector #(.SHARE_GROUP_SIZE(N), .MSG_BITWIDTH(W), .MAX_SEQ_LEN(M)) dut (
        .sys_clk(sys_clk),
        .rstn   (rstn),
        .bus    (bus)
    );

    typedef struct {
        logic [N*W-1:0] data;
        logic [N-1:0]   mask;
        int             beats;
        bit             seq;
        bit             err;
        bit             conf;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   rnd_rdy = 1'b0;

    // reference model: canonical lanes of the open group
    int lv[N];
    bit ls[N];
    int m_beats;
    bit m_err, m_conf;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void model_clear_group();
        for (int k = 0; k < N; k++) begin
            lv[k] = 0;
            ls[k] = 1'b0;
        end
        m_beats = 0;
        m_conf  = 1'b0;
    endfunction

    function automatic void model_beat(input logic [N*W-1:0] d, input int s, input logic [N-1:0] m, input bit g);
        exp_t e;
        bit   closes;
        m_beats++;
        if (s < N) begin
            for (int k = 0; k < N; k++) begin
                if (m[k]) begin
                    if (ls[k]) m_conf = 1'b1;
                    lv[k] = int'((d >> (W * ((k + s) % N))) & 15);
                    ls[k] = 1'b1;
                end
            end
        end else begin
            m_err = 1'b1;
        end
`ifdef MEMSHARE_COLLECT_CONFLICT_CHECK_EN
        if (m_conf) m_err = 1'b1;
`endif
        closes = g || (m_beats == M);
        if (closes) begin
            e.seq = !g;
            if (!g) m_err = 1'b1;
            e.data = '0;
            e.mask = '0;
            for (int k = 0; k < N; k++) begin
                e.data[k*W +: W] = 4'(lv[k]);
                e.mask[k]        = ls[k];
            end
            e.beats = m_beats;
            e.err   = m_err;
            e.conf  = m_conf;
            q.push_back(e);
            model_clear_group();
        end
    endfunction

    task automatic send(input logic [N*W-1:0] d, input int s, input logic [N-1:0] m, input bit g);
        int t = 0;
        bus.in_valid_i   = 1'b1;
        bus.rdata_i      = d;
        bus.l1pa_shift_i = 3'(s);
        bus.lane_mask_i  = m;
        bus.isGtr_i      = g;
        @(negedge sys_clk);
        while (!bus.in_ready_o && t < 200) begin
            @(negedge sys_clk);
            t++;
        end
        if (!bus.in_ready_o) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready stuck low");
        end else begin
            model_beat(d, s, m, g);
        end
        @(posedge sys_clk);
        #1;
        bus.in_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge sys_clk);
            t++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d groups outstanding", q.size());
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_in_ready"}, 32'(bus.in_ready_o), 32'd1);
        chk({nm, "_out_valid"}, 32'(bus.out_valid_o), 32'd0);
        chk({nm, "_out_data"}, 32'(bus.out_data_o), 32'd0);
        chk({nm, "_out_mask"}, 32'(bus.out_lane_mask_o), 32'd0);
        chk({nm, "_out_beats"}, 32'(bus.out_beats_o), 32'd0);
        chk({nm, "_seq_err"}, 32'(bus.seq_err_o), 32'd0);
        chk({nm, "_err"}, 32'(bus.err_o), 32'd0);
`ifdef MEMSHARE_COLLECT_CONFLICT_CHECK_EN
        chk({nm, "_conflict"}, 32'(bus.conflict_o), 32'd0);
`endif
    endtask

    // monitor: every output handshake retires one expected group
    always @(negedge sys_clk) begin
        if (rstn && bus.out_valid_o && bus.out_ready_i) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_group: data %0h mask %0h", bus.out_data_o, bus.out_lane_mask_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("grp_data", 32'(bus.out_data_o), 32'(e.data));
                chk("grp_mask", 32'(bus.out_lane_mask_o), 32'(e.mask));
                chk("grp_beats", 32'(bus.out_beats_o), 32'(e.beats));
                chk("grp_seq_err", 32'(bus.seq_err_o), 32'(e.seq));
                chk("grp_err", 32'(bus.err_o), 32'(e.err));
`ifdef MEMSHARE_COLLECT_CONFLICT_CHECK_EN
                chk("grp_conflict", 32'(bus.conflict_o), 32'(e.conf));
`endif
            end
        end
    end

    always @(posedge sys_clk) begin
        if (rnd_rdy) begin
            #1;
            bus.out_ready_i = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid_i   = 1'b0;
        bus.rdata_i      = '0;
        bus.l1pa_shift_i = '0;
        bus.lane_mask_i  = '0;
        bus.isGtr_i      = 1'b0;
        bus.out_ready_i  = 1'b1;
        model_clear_group();
        m_err = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk_idle("reset");
        rstn = 1'b1;
        @(negedge sys_clk);
        chk_idle("post_reset");

        // rotation and single-cycle latency
        @(posedge sys_clk); #1;
        send(20'h54321, 2, 5'b11111, 1'b1);
        @(negedge sys_clk);
        chk("lat_valid", 32'(bus.out_valid_o), 32'd1);
        chk("rot_data", 32'(bus.out_data_o), 32'h21543);
        wait_drain();

        // three-beat group
        send(20'($urandom), 0, 5'b00011, 1'b0);
        send(20'($urandom), 1, 5'b01100, 1'b0);
        send(20'($urandom), 4, 5'b10000, 1'b1);
        wait_drain();

        // overflow then a fresh group, err stays set
        for (int i = 0; i < M; i++) send(20'($urandom), i % N, 5'(1 << i), 1'b0);
        wait_drain();
        chk("err_sticky", 32'(bus.err_o), 32'd1);
        send(20'($urandom), 3, 5'b11111, 1'b1);
        wait_drain();

        // backpressure: one pending group, stall, then drain and close together
        bus.out_ready_i = 1'b0;
        send(20'($urandom), 1, 5'b10101, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            chk("stall_in_ready", 32'(bus.in_ready_o), 32'd0);
            chk("stall_valid", 32'(bus.out_valid_o), 32'd1);
            chk("stall_data", 32'(bus.out_data_o), 32'(q[0].data));
        end
        @(posedge sys_clk); #1;
        bus.out_ready_i = 1'b1;
        send(20'($urandom), 2, 5'b01010, 1'b1);
        @(negedge sys_clk);
        chk("no_bubble_valid", 32'(bus.out_valid_o), 32'd1);
        wait_drain();

        // illegal shift closes with only the previous beat
        send(20'($urandom), 0, 5'b00001, 1'b0);
        send(20'($urandom), 5, 5'b11111, 1'b1);
        wait_drain();

        // two writes to lane 0: last one wins
        send(20'h00003, 0, 5'b00001, 1'b0);
        send(20'h00007, 0, 5'b00001, 1'b1);
        wait_drain();

        // back-to-back single-beat groups at full rate
        for (int i = 0; i < 6; i++) send(20'($urandom), $urandom_range(0, 4), 5'($urandom), 1'b1);
        wait_drain();

        // random traffic with random consumer stalls
        rnd_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int s;
            s = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
            send(20'($urandom), s, 5'($urandom), $urandom_range(0, 2) == 0);
        end
        rnd_rdy = 1'b0;
        @(posedge sys_clk); #2;
        bus.out_ready_i = 1'b1;
        send(20'($urandom), 0, 5'b11111, 1'b1);
        wait_drain();

        // reset mid-group discards the partial group
        send(20'($urandom), 1, 5'b00110, 1'b0);
        send(20'($urandom), 2, 5'b11000, 1'b0);
        @(negedge sys_clk);
        rstn = 1'b0;
        #1;
        chk_idle("mid_reset");
        model_clear_group();
        m_err = 1'b0;
        @(negedge sys_clk);
        rstn = 1'b1;
        @(posedge sys_clk); #1;
        send(20'($urandom), 4, 5'b01001, 1'b1);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
